// File: rtl/octree_sram_pkg.sv
// ============================================================================
// Package : octree_sram_pkg
// Brief   : Shared defaults, per-bank request/response types, RR helper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package octree_sram_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_BANKS_DEF  = 4;
    localparam int NUM_PORTS_DEF  = 2;
    localparam int RD_LAT_DEF     = 1;

    // Port IDs are carried at a fixed width; supports up to 256 requesters.
    localparam int PID_W = 8;

    typedef logic [PID_W-1:0] port_id_t;

    typedef struct packed {
        logic     en;
        logic     we;
        port_id_t port;
    } bank_req_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } bank_rsp_t;

    // Port index k positions after 'last', wrapping at n (last < n, 1 <= k <= n).
    function automatic int rr_next(input int last, input int k, input int n);
        int i;
        i = last + k;
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

`default_nettype wire

// File: rtl/in_out_sram_banked_if.sv
// ============================================================================
// Interface : in_out_sram_banked_if
// Brief     : Flat multi-port request/response bundle for the banked SRAM.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface in_out_sram_banked_if
    import octree_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF
);
    logic [NUM_PORTS-1:0]              req;
    logic [NUM_PORTS-1:0]              gnt;
    logic [NUM_PORTS-1:0]              we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0] be;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata;
    logic [NUM_PORTS-1:0]              rvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/sram_bank.sv
// ============================================================================
// Module : sram_bank
// Brief  : Single-port byte-enabled array with one-cycle synchronous read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_bank
    import octree_sram_pkg::*;
#(
    parameter int ROW_W      = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  wire logic                    clk,
    input  wire logic                    i_en,
    input  wire logic                    i_we,
    input  wire logic [ROW_W-1:0]        i_row,
    input  wire logic [DATA_WIDTH/8-1:0] i_be,
    input  wire logic [DATA_WIDTH-1:0]   i_wdata,
    output logic      [DATA_WIDTH-1:0]   o_rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ROW_W];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (i_be[i]) begin
                    mem_q[i_row][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
        if (i_en && !i_we) begin
            rdata_q <= mem_q[i_row];
        end
    end

    assign o_rdata = rdata_q;
endmodule

`default_nettype wire

// File: rtl/in_out_sram_banked.sv
// ============================================================================
// Module : in_out_sram_banked
// Brief  : Multi-port banked SRAM, per-bank round-robin, RD_LAT read latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module in_out_sram_banked
    import octree_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_BANKS  = NUM_BANKS_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic [NUM_PORTS-1:0]              req_i,
    output logic      [NUM_PORTS-1:0]              gnt_o,
    input  wire logic [NUM_PORTS-1:0]              we_i,
    input  wire logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  wire logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  wire logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic      [NUM_PORTS-1:0]              rvalid_o,
    output logic      [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_WIDTH - BANK_W;
    localparam int BE_W   = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]  w_hit     [NUM_BANKS];
    bank_req_t             w_breq    [NUM_BANKS];
    logic [ROW_W-1:0]      w_row     [NUM_BANKS];
    logic [BE_W-1:0]       w_be      [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_wdata   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_brdata  [NUM_BANKS];
    bank_rsp_t             w_out_meta[NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_out_data[NUM_BANKS];

    port_id_t              ptr_q [NUM_BANKS], ptr_d [NUM_BANKS];
    bank_rsp_t             meta_q[NUM_BANKS], meta_d[NUM_BANKS];
    logic [DATA_WIDTH-1:0] hold_q[NUM_PORTS], hold_d[NUM_PORTS];

    // Reset masks every request, which also blocks writes while rst is high.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_hit[b][p] = req_i[p] & ~rst &
                              (addr_i[p*ADDR_WIDTH +: BANK_W] == BANK_W'(b));
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_breq[b] = '0;
            ptr_d[b]  = ptr_q[b];
            for (int k = 1; k <= NUM_PORTS; k++) begin
                if (!w_breq[b].en && w_hit[b][rr_next(int'(ptr_q[b]), k, NUM_PORTS)]) begin
                    w_breq[b].en   = 1'b1;
                    w_breq[b].port = port_id_t'(rr_next(int'(ptr_q[b]), k, NUM_PORTS));
                end
            end
            w_breq[b].we = w_breq[b].en & we_i[w_breq[b].port];
            if (w_breq[b].en) begin
                gnt_o[w_breq[b].port] = 1'b1;
                ptr_d[b]              = w_breq[b].port;
            end
            w_row[b]   = addr_i[int'(w_breq[b].port)*ADDR_WIDTH + BANK_W +: ROW_W];
            w_be[b]    = be_i[int'(w_breq[b].port)*BE_W +: BE_W];
            w_wdata[b] = wdata_i[int'(w_breq[b].port)*DATA_WIDTH +: DATA_WIDTH];
            meta_d[b]  = '{valid: w_breq[b].en & ~w_breq[b].we, port: w_breq[b].port};
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank #(
            .ROW_W      (ROW_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .i_en    (w_breq[b].en),
            .i_we    (w_breq[b].we),
            .i_row   (w_row[b]),
            .i_be    (w_be[b]),
            .i_wdata (w_wdata[b]),
            .o_rdata (w_brdata[b])
        );
    end

    // Bank output lines up with meta_q; extra stages stretch both to RD_LAT.
    if (RD_LAT > 1) begin : g_pipe
        bank_rsp_t             pmeta_q[NUM_BANKS][RD_LAT-1], pmeta_d[NUM_BANKS][RD_LAT-1];
        logic [DATA_WIDTH-1:0] pdata_q[NUM_BANKS][RD_LAT-1], pdata_d[NUM_BANKS][RD_LAT-1];

        always_comb begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                pmeta_d[b][0] = meta_q[b];
                pdata_d[b][0] = w_brdata[b];
                for (int s = 1; s < RD_LAT-1; s++) begin
                    pmeta_d[b][s] = pmeta_q[b][s-1];
                    pdata_d[b][s] = pdata_q[b][s-1];
                end
                w_out_meta[b] = pmeta_q[b][RD_LAT-2];
                w_out_data[b] = pdata_q[b][RD_LAT-2];
            end
        end

        always_ff @(posedge clk) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < RD_LAT-1; s++) begin
                    if (rst) begin
                        pmeta_q[b][s] <= '0;
                        pdata_q[b][s] <= '0;
                    end else begin
                        pmeta_q[b][s] <= pmeta_d[b][s];
                        pdata_q[b][s] <= pdata_d[b][s];
                    end
                end
            end
        end
    end else begin : g_nopipe
        always_comb begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_out_meta[b] = meta_q[b];
                w_out_data[b] = w_brdata[b];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hold_d[p] = hold_q[p];
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_out_meta[b].valid && (w_out_meta[b].port == port_id_t'(p))) begin
                    rvalid_o[p] = ~rst;
                    hold_d[p]   = w_out_data[b];
                end
            end
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rst ? '0 : hold_d[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b]  <= port_id_t'(NUM_PORTS - 1);
                meta_q[b] <= '0;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_q[p] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            meta_q <= meta_d;
            hold_q <= hold_d;
        end
    end
endmodule

`default_nettype wire

// File: doc/in_out_sram_banked.md
IN_OUT_SRAM_BANKED -- requirements
Module: in_out_sram_banked

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width (1024 words total).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width; multiple of 8.
REQ-003 SHALL have parameter NUM_BANKS, default 4, power of two, at least 2, at most 2^ADDR_WIDTH.
REQ-004 SHALL have parameter NUM_PORTS, default 2, requester channels, at least 1.
REQ-005 SHALL have parameter RD_LAT, default 1, grant-to-rvalid cycles, at least 1.
REQ-006 SHALL have port clk  in  1  sole clock; rising edge.
REQ-007 SHALL have port rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-008 SHALL have port req_i  in  NUM_PORTS  per-port request.
REQ-009 SHALL have port gnt_o  out  NUM_PORTS  per-port grant; the access is accepted in a cycle where req_i and gnt_o are both high.
REQ-010 SHALL have port we_i  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
REQ-011 SHALL have port addr_i  in  NUM_PORTS*ADDR_WIDTH  flat per-port word address; port p occupies slice p.
REQ-012 SHALL have port be_i  in  NUM_PORTS*DATA_WIDTH/8  flat per-port byte enables.
REQ-013 SHALL have port wdata_i  in  NUM_PORTS*DATA_WIDTH  flat per-port write data.
REQ-014 SHALL have port rvalid_o  out  NUM_PORTS  per-port read-data-valid pulse.
REQ-015 SHALL have port rdata_o  out  NUM_PORTS*DATA_WIDTH  flat per-port read data.

Function
REQ-016 SHALL decode the bank as addr[log2(NUM_BANKS)-1:0] and the row as the remaining upper bits; bank depth is 2^ADDR_WIDTH/NUM_BANKS.
REQ-017 SHALL grant, per bank, at most one port per cycle; requests to different banks SHALL be granted in the same cycle.
REQ-018 SHALL compute gnt_o combinationally from req_i, the decoded bank and the arbiter state; gnt_o SHALL be 0 for any port with req_i low.
REQ-019 SHALL arbitrate each bank round-robin: highest priority goes to the port after that bank's last granted port, and a bank's pointer SHALL update only in a cycle in which that bank grants.
REQ-020 SHALL leave a non-granted port's request pending with no side effect; the requester holds req_i, we_i, addr_i, be_i and wdata_i stable until it is granted.
REQ-021 SHALL, on a granted write, update exactly the bytes whose be_i bit is 1 at the next clock edge; a write with be_i all-zero SHALL be granted and SHALL leave memory unchanged.
REQ-022 SHALL, on a granted read, pulse rvalid_o[p] for exactly one cycle exactly RD_LAT cycles after the grant cycle, with rdata_o[p] holding the addressed word in that cycle.
REQ-023 SHALL sustain one granted read per port per cycle (back-to-back), returning results in grant order.
REQ-024 SHALL hold rdata_o[p] at its last returned value while rvalid_o[p] is low; granted writes SHALL NOT raise rvalid_o.
REQ-025 SHALL return the new data for a read granted in the cycle after a write to the same address, from any port (no stale read).
REQ-026 SHALL leave the contents of never-written locations undefined; there is no memory initialisation.

Reset
REQ-027 SHALL, while rst is high, drive gnt_o = 0 and rvalid_o = 0, and set rdata_o to all zeros.
REQ-028 SHALL, while rst is high, set every bank's round-robin pointer so that port 0 has highest priority.
REQ-029 SHALL discard reads in flight when rst asserts: no rvalid_o pulse from a pre-reset grant SHALL ever appear.
REQ-030 SHALL preserve memory contents across reset; no write SHALL occur in a cycle where rst is high.

Structure
REQ-031 SHALL place default parameter constants and the per-bank request/response struct typedefs in shared package octree_sram_pkg.
REQ-032 SHALL instantiate NUM_BANKS copies of sub-module sram_bank, a single-port, byte-enabled, one-cycle synchronous-read behavioural array.
REQ-033 SHALL implement round-robin arbiters, response routing and the RD_LAT-1 additional valid/data/port-ID pipeline stages in in_out_sram_banked.

Verification
REQ-034 SHALL cover: defaults; port 0 writes 0x1122334455667788 to address 5 with be=0xFF; then port 0 reads address 5 -> rvalid_o[0] high 1 cycle after the read grant, data 0x1122334455667788.
REQ-035 SHALL cover: write 0xAAAAAAAAAAAAAAAA to address 8 with be=0xFF, then write 0x00 to address 8 with be=0x0F -> a read of address 8 returns 0xAAAAAAAA00000000.
REQ-036 SHALL cover: ports 0 and 1 both reading addresses 4 and 8 (both bank 0) for 4 cycles -> grants alternate 0,1,0,1; no gnt_o value is ever 2'b11.
REQ-037 SHALL cover: port 0 accessing address 1 and port 1 accessing address 2 in the same cycle -> gnt_o=2'b11, and both rvalid_o bits pulse together.
REQ-038 SHALL cover: RD_LAT=3; 3 back-to-back reads of addresses 0,1,2 -> rvalid_o high for 3 consecutive cycles starting 3 cycles after the first grant, data in order.
REQ-039 SHALL cover: rst asserted for one cycle, one cycle after a granted read with RD_LAT=3 -> no rvalid_o pulse; previously written data is still readable after reset.
